// File: rtl/cyclone_io_arb_pkg.sv
// Shared types for the Cyclone I/O pad arbiter: FSM state encoding and
// the width helper for the single phase down-counter.
package cyclone_io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        LISTEN = 2'd3
    } state_t;

    // Wide enough to hold the longest phase (a word or the turnaround gap).
    function automatic int cnt_width(input int width, input int turn);
        int m;
        m = (width > turn) ? width : turn;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cyclone_io_arbiter_if.sv
// Pad-arbiter bus: requester handshake, pad pins and receive capture.
// master = requesters/pad side, slave = cyclone_io_arbiter.
interface cyclone_io_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic             owner;
    logic             busy;
    logic             io_datain;
    logic             io_oe;
    logic             io_padin;
    logic             rx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;

    modport master (
        output req, data0, data1, io_padin, rx_req,
        input  gnt, owner, busy, io_datain, io_oe, rx_data, rx_valid
    );

    modport slave (
        input  req, data0, data1, io_padin, rx_req,
        output gnt, owner, busy, io_datain, io_oe, rx_data, rx_valid
    );
endinterface

// File: rtl/cyclone_io_rr_arb.sv
// Two-way round-robin picker. Ports: clock, sclr (sync, active high),
// req (requests), take (grant happens this edge), pick (one-hot winner).
module cyclone_io_rr_arb (
    input  logic       clock,
    input  logic       sclr,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] pick
);
    // Index of the requester served last; starts at 1 so requester 0 wins.
    logic ptr;

    always_comb begin
        pick = 2'b00;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = ptr ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            ptr <= 1'b1;
        end else if (take) begin
            ptr <= pick[1];
        end
    end
endmodule

// File: rtl/cyclone_io_arbiter.sv
// Shares one bidirectional pad between two transmit requesters and an
// optional receive listener; words go out LSB-first followed by an
// oe-low turnaround gap.
// Ports: clock, sclr (sync, active high), bus (cyclone_io_arbiter_if.slave).
// Build option: CYCLONE_IO_ARB_RX_CAPTURE_EN adds the LISTEN state and the
// receive shift register; otherwise rx_req/io_padin are ignored and
// rx_data/rx_valid are held at 0.
module cyclone_io_arbiter
    import cyclone_io_arb_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input logic                  clock,
    input logic                  sclr,
    cyclone_io_arbiter_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH, TURN_CYCLES);
    localparam logic [CW-1:0] DRIVE_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] TURN_LOAD =
        (TURN_CYCLES > 0) ? CW'(TURN_CYCLES - 1) : '0;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx_sh;
    logic [1:0]       pick;
    logic             take;
    logic [WIDTH-1:0] sel_data;

    logic [1:0] gnt_q;
    logic       owner_q;
    logic       busy_q;
    logic       datain_q;
    logic       oe_q;

    assign take     = (state == IDLE) && (bus.req != 2'b00);
    assign sel_data = pick[1] ? bus.data1 : bus.data0;

    cyclone_io_rr_arb u_rr (
        .clock (clock),
        .sclr  (sclr),
        .req   (bus.req),
        .take  (take),
        .pick  (pick)
    );

`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;

    // New sample enters at the MSB so bit 0 ends up holding the first one.
    assign rx_next = WIDTH'({bus.io_padin, rx_sh} >> 1);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`else
    logic unused_rx;
    assign unused_rx    = bus.rx_req ^ bus.io_padin;
    assign bus.rx_data  = '0;
    assign bus.rx_valid = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (sclr) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_sh    <= '0;
            gnt_q    <= 2'b00;
            owner_q  <= 1'b0;
            busy_q   <= 1'b0;
            datain_q <= 1'b0;
            oe_q     <= 1'b0;
`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
            rx_sh      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`endif
        end else begin
            gnt_q <= 2'b00;
`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
            rx_valid_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        // Bit 0 goes out on the grant cycle itself.
                        gnt_q    <= pick;
                        owner_q  <= pick[1];
                        tx_sh    <= sel_data >> 1;
                        datain_q <= sel_data[0];
                        oe_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt      <= DRIVE_LOAD;
                        state    <= DRIVE;
                    end
`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
                    else if (bus.rx_req) begin
                        busy_q <= 1'b1;
                        cnt    <= DRIVE_LOAD;
                        state  <= LISTEN;
                    end
`endif
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        oe_q     <= 1'b0;
                        datain_q <= 1'b0;
                        if (TURN_CYCLES == 0) begin
                            busy_q <= 1'b0;
                            cnt    <= '0;
                            state  <= IDLE;
                        end else begin
                            cnt   <= TURN_LOAD;
                            state <= TURN;
                        end
                    end else begin
                        datain_q <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        cnt      <= cnt - 1'b1;
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LISTEN: begin
`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
                    rx_sh <= rx_next;
                    if (cnt == '0) begin
                        rx_data_q  <= rx_next;
                        rx_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`else
                    busy_q <= 1'b0;
                    state  <= IDLE;
`endif
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
    assign bus.io_datain = datain_q;
    assign bus.io_oe     = oe_q;
endmodule

// File: tb/tb_cyclone_io_arbiter.sv
// Self-checking bench for cyclone_io_arbiter: a WIDTH=8/TURN=2 instance
// with a transmit/receive scoreboard, plus a TURN_CYCLES=0 instance.
module tb_cyclone_io_arbiter;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0]   gnt;
        logic [W-1:0] word;
    } tx_t;

    logic clock = 1'b0;
    logic sclr;

    cyclone_io_arbiter_if #(.WIDTH(W)) bus_a ();
    cyclone_io_arbiter_if #(.WIDTH(W)) bus_b ();

    cyclone_io_arbiter #(.WIDTH(W), .TURN_CYCLES(2)) u_a (
        .clock (clock),
        .sclr  (sclr),
        .bus   (bus_a)
    );

    cyclone_io_arbiter #(.WIDTH(W), .TURN_CYCLES(0)) u_b (
        .clock (clock),
        .sclr  (sclr),
        .bus   (bus_b)
    );

    always #5 clock = ~clock;

    tx_t          txq[$];
    logic [W-1:0] rxq[$];
    int           n_chk;
    int           n_pass;
    int           cyc;
    logic         mptr;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] model_pick(input logic [1:0] r);
        if (r == 2'b11) return mptr ? 2'b01 : 2'b10;
        return r;
    endfunction

    task automatic wait_gnt(input bit on_b, input int lim,
                            output logic [1:0] g, output int t);
        g = 2'b00;
        t = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (on_b && bus_b.gnt != 2'b00) begin
                g = bus_b.gnt;
                t = cyc;
                break;
            end
            if (!on_b && bus_a.gnt != 2'b00) begin
                g = bus_a.gnt;
                t = cyc;
                break;
            end
        end
        if (g == 2'b00) chk("gnt_timeout", 0, 1);
    endtask

    task automatic do_reset();
        bus_a.req    = 2'b00;
        bus_a.rx_req = 1'b0;
        bus_b.req    = 2'b00;
        sclr = 1'b1;
        repeat (2) @(negedge clock);
        sclr = 1'b0;
        mptr = 1'b1;
    endtask

    // Transmit/receive monitor for instance A: rebuilds each word from the
    // pad and checks it against the scoreboard.
    initial begin : mon
        bit           active;
        int           nb;
        logic [W-1:0] cap;
        logic [1:0]   cg;
        tx_t          e;
        active = 0;
        nb = 0;
        forever begin
            @(negedge clock);
            if (sclr) begin
                active = 0;
            end else begin
                if (bus_a.gnt != 2'b00) begin
                    active = 1;
                    nb = 0;
                    cg = bus_a.gnt;
                    cap = '0;
                end
                if (active) begin
                    if (!bus_a.io_oe) begin
                        chk("tx_oe_held", 0, 1);
                        active = 0;
                    end else begin
                        cap[nb] = bus_a.io_datain;
                        nb++;
                        if (nb == W) begin
                            active = 0;
                            if (txq.size() == 0) begin
                                chk("tx_unexpected", 1, 0);
                            end else begin
                                e = txq.pop_front();
                                chk("tx_gnt", cg, e.gnt);
                                chk("tx_word", cap, e.word);
                            end
                        end
                    end
                end
                if (bus_a.rx_valid) begin
                    if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
                    else chk("rx_word", bus_a.rx_data, rxq.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [1:0]   g;
        logic [1:0]   e;
        int           t;
        int           prev;
        logic [W-1:0] cap;
        logic [W-1:0] rxbits;
        tx_t          ex;

        n_chk = 0;
        n_pass = 0;
        mptr = 1'b1;
        bus_a.req = 2'b00;
        bus_a.data0 = '0;
        bus_a.data1 = '0;
        bus_a.io_padin = 1'b0;
        bus_a.rx_req = 1'b0;
        bus_b.req = 2'b00;
        bus_b.data0 = '0;
        bus_b.data1 = '0;
        bus_b.io_padin = 1'b0;
        bus_b.rx_req = 1'b0;
        sclr = 1'b1;

        repeat (3) @(negedge clock);
        chk("rst_gnt", bus_a.gnt, 0);
        chk("rst_owner", bus_a.owner, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_oe", bus_a.io_oe, 0);
        chk("rst_datain", bus_a.io_datain, 0);
        chk("rst_rx_valid", bus_a.rx_valid, 0);
        chk("rst_rx_data", bus_a.rx_data, 0);
        sclr = 1'b0;

        // Single word
        bus_a.data0 = 8'hA5;
        bus_a.req = 2'b01;
        txq.push_back(tx_t'({2'b01, 8'hA5}));
        wait_gnt(0, 10, g, t);
        chk("single_gnt", g, 2'b01);
        chk("single_owner", bus_a.owner, 0);
        bus_a.req = 2'b00;
        mptr = 1'b0;
        @(negedge clock);
        chk("single_gnt_pulse", bus_a.gnt, 0);
        repeat (6) @(negedge clock);
        chk("single_oe_last", bus_a.io_oe, 1);
        @(negedge clock);
        chk("single_turn_oe", bus_a.io_oe, 0);
        chk("single_turn_dat", bus_a.io_datain, 0);
        chk("single_turn_busy", bus_a.busy, 1);
        @(negedge clock);
        chk("single_turn2_oe", bus_a.io_oe, 0);
        chk("single_turn2_busy", bus_a.busy, 1);
        @(negedge clock);
        chk("single_idle_busy", bus_a.busy, 0);

        // Contention: alternating grants, 11 cycles apart
        do_reset();
        bus_a.data0 = 8'h11;
        bus_a.data1 = 8'h22;
        bus_a.req = 2'b11;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            e = model_pick(bus_a.req);
            ex.gnt = e;
            ex.word = e[1] ? bus_a.data1 : bus_a.data0;
            txq.push_back(ex);
            wait_gnt(0, 20, g, t);
            chk("cont_gnt", g, e);
            chk("cont_owner", bus_a.owner, e[1]);
            if (i > 0) chk("cont_spacing", t - prev, 11);
            prev = t;
            mptr = e[1];
            if (e[1]) bus_a.data1 = bus_a.data1 + 8'h13;
            else bus_a.data0 = bus_a.data0 + 8'h35;
        end
        bus_a.req = 2'b00;
        repeat (12) @(negedge clock);
        chk("cont_idle", bus_a.busy, 0);

        // Reset in DRIVE cycle 3
        do_reset();
        bus_a.data0 = 8'h5A;
        bus_a.data1 = 8'hC3;
        bus_a.req = 2'b11;
        wait_gnt(0, 5, g, t);
        chk("mid_first_gnt", g, 2'b01);
        repeat (3) @(negedge clock);
        sclr = 1'b1;
        @(negedge clock);
        chk("mid_oe", bus_a.io_oe, 0);
        chk("mid_busy", bus_a.busy, 0);
        chk("mid_gnt", bus_a.gnt, 0);
        @(negedge clock);
        sclr = 1'b0;
        mptr = 1'b1;
        txq.push_back(tx_t'({2'b01, 8'h5A}));
        wait_gnt(0, 5, g, t);
        chk("mid_regrant", g, 2'b01);
        bus_a.req = 2'b00;
        mptr = 1'b0;
        repeat (12) @(negedge clock);

        // Zero turnaround on instance B
        bus_b.data0 = 8'h6B;
        bus_b.req = 2'b01;
        wait_gnt(1, 5, g, prev);
        chk("zt_gnt", g, 2'b01);
        cap = '0;
        cap[0] = bus_b.io_datain;
        for (int k = 1; k < W; k++) begin
            @(negedge clock);
            cap[k] = bus_b.io_datain;
        end
        bus_b.data0 = 8'hD2;
        chk("zt_word", cap, 8'h6B);
        @(negedge clock);
        chk("zt_gap_oe", bus_b.io_oe, 0);
        chk("zt_gap_gnt", bus_b.gnt, 0);
        @(negedge clock);
        chk("zt_gnt2", bus_b.gnt, 2'b01);
        chk("zt_oe2", bus_b.io_oe, 1);
        chk("zt_spacing", cyc - prev, 9);
        bus_b.req = 2'b00;
        cap = '0;
        cap[0] = bus_b.io_datain;
        for (int k = 1; k < W; k++) begin
            @(negedge clock);
            cap[k] = bus_b.io_datain;
        end
        chk("zt_word2", cap, 8'hD2);
        repeat (3) @(negedge clock);
        chk("zt_idle", bus_b.busy, 0);

        // Receive window
        do_reset();
`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
        rxbits = 8'h3C;
        rxq.push_back(rxbits);
        bus_a.rx_req = 1'b1;
        @(negedge clock);
        chk("rx_busy", bus_a.busy, 1);
        chk("rx_oe", bus_a.io_oe, 0);
        bus_a.rx_req = 1'b0;
        bus_a.io_padin = rxbits[0];
        for (int k = 1; k < W; k++) begin
            @(negedge clock);
            chk("rx_oe_low", bus_a.io_oe, 0);
            bus_a.io_padin = rxbits[k];
        end
        @(negedge clock);
        chk("rx_valid", bus_a.rx_valid, 1);
        @(negedge clock);
        chk("rx_valid_pulse", bus_a.rx_valid, 0);
        chk("rx_done_busy", bus_a.busy, 0);
`else
        rxbits = 8'hFF;
        bus_a.rx_req = 1'b1;
        bus_a.io_padin = rxbits[0];
        repeat (10) @(negedge clock);
        chk("norx_busy", bus_a.busy, 0);
        chk("norx_valid", bus_a.rx_valid, 0);
        chk("norx_oe", bus_a.io_oe, 0);
        bus_a.rx_req = 1'b0;
`endif

        // Priority: transmit beats rx_req, LISTEN only after TURN
        do_reset();
        bus_a.data1 = 8'h96;
        bus_a.req = 2'b10;
        bus_a.rx_req = 1'b1;
        txq.push_back(tx_t'({2'b10, 8'h96}));
        wait_gnt(0, 5, g, t);
        chk("prio_gnt", g, 2'b10);
        bus_a.req = 2'b00;
        repeat (8) @(negedge clock);
        chk("prio_turn_oe", bus_a.io_oe, 0);
        chk("prio_turn_busy", bus_a.busy, 1);
        repeat (2) @(negedge clock);
        chk("prio_idle_busy", bus_a.busy, 0);
        @(negedge clock);
`ifdef CYCLONE_IO_ARB_RX_CAPTURE_EN
        chk("prio_listen_busy", bus_a.busy, 1);
        chk("prio_listen_oe", bus_a.io_oe, 0);
        rxq.push_back(8'h00);
        bus_a.rx_req = 1'b0;
        bus_a.io_padin = 1'b0;
        repeat (9) @(negedge clock);
`else
        chk("prio_nolisten", bus_a.busy, 0);
        bus_a.rx_req = 1'b0;
`endif

        repeat (3) @(negedge clock);
        chk("txq_empty", txq.size(), 0);
        chk("rxq_empty", rxq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cyclone_io_arbiter.md
# cyclone_io_arbiter

Shares one bidirectional Cyclone I/O pad between two transmit requesters and an optional receive listener. Serializes a granted word LSB-first onto the pad's `datain`/`oe` pins, and inserts a programmable turnaround gap with `oe` low before the pad can be driven again. Sits directly in front of the DDIO/IO atom wrapper, which it drives.

## Interface
- `WIDTH`, 8: bits per word; must be ≥1.
- `TURN_CYCLES`, 2: `oe`-low gap after each transmit; 0 is legal.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `sclr` in 1: synchronous, active-high reset.
- `req` in 2: `req[i]` = requester i has a word pending.
- `data0` in WIDTH: requester 0 word.
- `data1` in WIDTH: requester 1 word.
- `gnt` out 2: one-hot, one-cycle pulse when a word is accepted.
- `owner` out 1: index of the requester currently driving.
- `busy` out 1: high in any state other than IDLE.
- `io_datain` out 1: to pad `datain`.
- `io_oe` out 1: to pad `oe`.
- `io_padin` in 1: pad readback.
- `rx_req` in 1: request a receive window.
- `rx_data` out WIDTH: captured word.
- `rx_valid` out 1: one-cycle strobe for `rx_data`.

## Operation
- States: IDLE, DRIVE, TURN, LISTEN.
- **Reset values:** all outputs 0. State IDLE; round-robin pointer = 1, so requester 0 wins first.
- **IDLE:** at an edge with `req != 0`, select a requester.
  - Only one requesting: that one wins.
  - Both requesting: the one not served last wins.
  - Same edge: register `gnt[sel]=1`, `owner=sel`, load the shift register from `data{sel}`, `io_oe=1`, `io_datain=data{sel}[0]`, go to DRIVE.
- **Handshake:** the requester holds `req` and data stable until it sees `gnt`. It may change them from the cycle after `gnt`. `req` is ignored outside IDLE.
- **DRIVE:** lasts exactly WIDTH cycles. Bit k appears on `io_datain` in DRIVE cycle k, with `io_oe=1` throughout. Then go to TURN, or to IDLE if TURN_CYCLES=0.
- **TURN:** lasts TURN_CYCLES cycles with `io_oe=0` and `io_datain=0`, then IDLE.
- **Priority:** transmit requests always beat `rx_req`. `rx_req` is taken only when `req==0`.
- **LISTEN** (macro only): lasts WIDTH cycles with `io_oe=0`. Sample `io_padin` LSB-first; bit k is sampled in LISTEN cycle k. At exit, pulse `rx_valid` for one cycle with `rx_data` valid and return to IDLE. No turnaround is inserted.
- **Counter:** one down-counter, width `$clog2(max(WIDTH,TURN_CYCLES)+1)`, reloaded on every state entry.
- **`sclr` mid-operation:** next edge gives reset values. `io_oe` drops to 0, the partial word is discarded, no `gnt`/`rx_valid` is issued, and the pointer returns to 1.

## Timing
- `gnt` to first bit on the pad: 0 cycles (same registered cycle).
- Transmit word period: IDLE(1) + WIDTH + TURN_CYCLES cycles from one `gnt` to the next, with continuous requests.
- `io_oe` falls the edge after the last DRIVE bit.
- `rx_valid` rises the edge after the last LISTEN sample.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CYCLONE_IO_ARB_RX_CAPTURE_EN` defined: LISTEN state and receive shift register are present.
- Not defined:
  - LISTEN is absent and `rx_req`/`io_padin` are ignored.
  - `rx_data` and `rx_valid` are tied to 0.
  - Ports remain so the interface is identical.

## Structure
- Package `cyclone_io_arb_pkg`: state enum (IDLE/DRIVE/TURN/LISTEN) and the counter-width function.
- Sub-module `cyclone_io_rr_arb`: two-way round-robin picker. Inputs are `req` and the pointer; outputs are the one-hot pick; it updates the pointer on grant.

## Test plan
- **Single word:** `req=01`, `data0=8'hA5` → `gnt=01` for 1 cycle; `io_oe=1` for 8 cycles with `io_datain` 1,0,1,0,0,1,0,1; then `io_oe=0` for 2 cycles; `busy` falls.
- **Contention:** `req=11` held continuously → grants alternate 01,10,01,…, spaced 11 cycles apart (WIDTH=8, TURN=2).
- **Zero turnaround:** TURN_CYCLES=0, back-to-back `req[0]` → next `gnt` exactly 9 cycles after the previous one, with a single `io_oe=0` cycle in IDLE.
- **Reset mid-word:** `sclr` in DRIVE cycle 3 → next edge `io_oe=0`, `busy=0`, pointer reset; the next `req=11` grants requester 0.
- **RX (macro on):** `rx_req=1`, `req=0`, `io_padin` drives 8'h3C LSB-first → `io_oe` stays 0; `rx_valid` pulses with `rx_data=8'h3C`.
- **Priority:** `rx_req` and `req[1]` asserted together → `gnt=10`; LISTEN starts only after TURN returns to IDLE.
